// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, memory
// access-size codes, the sequencer state type and small decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   // Memory access-size code for a given funct3 (low two bits carry the width).
   function automatic logic [1:0] sizeFromFunct3(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return SIZE_BYTE;
         2'b01:   return SIZE_HALF;
         default: return SIZE_WORD;
      endcase
   endfunction

   // Index of the last byte beat for an access of the given size (N-1).
   function automatic logic [1:0] lastBeat(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 2'd0;
         SIZE_HALF: return 2'd1;
         default:   return 2'd3;
      endcase
   endfunction

   // Encodings with no meaning: 011, 11x, and the unsigned forms on a store.
   function automatic logic isIllegal(input logic store, input logic [2:0] funct3);
      return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extension: sign- or zero-extends the low byte/halfword of the
// raw memory data according to the load funct3; words pass straight through.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   // Pick the extension rule from the load type.
   always_comb begin
      case (funct3_i)
         F3_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
         F3_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
         F3_BU:   data_o = {24'h000000, raw_i[7:0]};
         F3_HU:   data_o = {16'h0000, raw_i[15:0]};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit. Aligned accesses go to memory in one beat;
// misaligned halfword/word accesses are split into byte beats at consecutive
// addresses while the pipeline is stalled, and loads are reassembled.
module lsu
   import lsu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        fault,
   output logic [31:0] mem_address,
   output logic        mem_rw,
   output logic [1:0]  mem_access_size,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic        loadValid_q, loadValid_d;
   logic [31:0] loadData_q, loadData_d;
   logic        fault_q, fault_d;

   logic [1:0]  reqSize;
   logic        reqIllegal;
   logic        reqMisaligned;
   logic [31:0] asmMerged;
   logic [7:0]  beatByte;
   logic [31:0] extRaw;
   logic [2:0]  extFunct3;
   logic [31:0] extData;

   // Decode the live request: width, legality and alignment.
   always_comb begin
      reqSize       = sizeFromFunct3(req_funct3);
      reqIllegal    = isIllegal(req_store, req_funct3);
      reqMisaligned = ((reqSize == SIZE_HALF) && req_addr[0]) ||
                      ((reqSize == SIZE_WORD) && (req_addr[1:0] != 2'b00));
   end

   // Current split beat: assembly register with this beat's byte dropped in,
   // and the store byte that belongs to this beat.
   always_comb begin
      asmMerged = asm_q;
      asmMerged[{idx_q, 3'b000} +: 8] = mem_data_out[7:0];
      beatByte = wdata_q[{idx_q, 3'b000} +: 8];
   end

   // Extension input: live memory data for single-beat loads, the assembled
   // bytes and latched funct3 on the final split beat.
   always_comb begin
      if (state_q == SPLIT) begin
         extRaw    = asmMerged;
         extFunct3 = funct3_q;
      end else begin
         extRaw    = mem_data_out;
         extFunct3 = req_funct3;
      end
   end

   lsu_load_ext uLoadExt (
      .raw_i    (extRaw),
      .funct3_i (extFunct3),
      .data_o   (extData)
   );

   // Sequencer: drives the memory port, stall, and next-state of the latched
   // request, beat index, assembly register and registered result pulses.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      store_d         = store_q;
      funct3_d        = funct3_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      asm_d           = asm_q;
      loadValid_d     = 1'b0;
      loadData_d      = loadData_q;
      fault_d         = 1'b0;
      stall           = 1'b0;
      mem_address     = req_addr;
      mem_rw          = 1'b0;
      mem_access_size = SIZE_WORD;
      mem_data_in     = req_wdata;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (reqIllegal) begin
                  fault_d = 1'b1;
               end else if (!reqMisaligned) begin
                  mem_rw          = req_store;
                  mem_access_size = reqSize;
                  if (!req_store) begin
                     loadValid_d = 1'b1;
                     loadData_d  = extData;
                  end
               end else begin
                  mem_rw          = req_store;
                  mem_access_size = SIZE_BYTE;
                  mem_data_in     = {24'h000000, req_wdata[7:0]};
                  store_d         = req_store;
                  funct3_d        = req_funct3;
                  addr_d          = req_addr;
                  wdata_d         = req_wdata;
                  asm_d           = {24'h000000, mem_data_out[7:0]};
                  idx_d           = 2'd1;
                  state_d         = SPLIT;
                  stall           = 1'b1;
               end
            end
         end

         SPLIT: begin
            mem_address     = addr_q + {30'b0, idx_q};
            mem_rw          = store_q;
            mem_access_size = SIZE_BYTE;
            mem_data_in     = {24'h000000, beatByte};
            asm_d           = asmMerged;
            if (idx_q == lastBeat(sizeFromFunct3(funct3_q))) begin
               state_d = IDLE;
               idx_d   = 2'd0;
               if (!store_q) begin
                  loadValid_d = 1'b1;
                  loadData_d  = extData;
                end
            end else begin
               idx_d = idx_q + 2'd1;
               stall = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase

      if (reset) begin
         mem_rw = 1'b0;
      end
   end

   // State and result registers; reset aborts any split in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         store_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         asm_q       <= 32'h0;
         loadValid_q <= 1'b0;
         loadData_q  <= 32'h0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         loadValid_q <= loadValid_d;
         loadData_q  <= loadData_d;
         fault_q     <= fault_d;
      end
   end

   assign load_valid = loadValid_q;
   assign load_data  = loadData_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: byte-array data memory, transaction-level reference model
// (byte-array memory plus an expected-result queue with due cycles), directed
// scenarios followed by randomized accesses.
module tb_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqStore;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        stall;
   logic        loadValid;
   logic [31:0] loadData;
   logic        fault;
   logic [31:0] memAddr;
   logic        memRw;
   logic [1:0]  memSize;
   logic [31:0] memDataIn;
   logic [31:0] memDataOut;

   int errors = 0;
   int checks = 0;
   int cycleCount = 0;
   bit monitorOn = 1'b0;

   logic [7:0] dmem   [0:1023];
   logic [7:0] refMem [0:1023];
   logic [9:0] a0;

   typedef struct {
      int          due;
      bit          isFault;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;

   lsu dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (reqValid),
      .req_store       (reqStore),
      .req_funct3      (reqFunct3),
      .req_addr        (reqAddr),
      .req_wdata       (reqWdata),
      .stall           (stall),
      .load_valid      (loadValid),
      .load_data       (loadData),
      .fault           (fault),
      .mem_address     (memAddr),
      .mem_rw          (memRw),
      .mem_access_size (memSize),
      .mem_data_in     (memDataIn),
      .mem_data_out    (memDataOut)
   );

   always #5 clock = ~clock;

   // Cycle counter used to time expected result pulses.
   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Data memory: combinational little-endian read, write on the rising edge.
   assign a0 = memAddr[9:0];
   assign memDataOut = {dmem[a0 + 10'd3], dmem[a0 + 10'd2], dmem[a0 + 10'd1], dmem[a0]};

   always @(posedge clock) begin
      if (memRw) begin
         dmem[a0] <= memDataIn[7:0];
         if (memSize != 2'b00) dmem[a0 + 10'd1] <= memDataIn[15:8];
         if (memSize == 2'b10) begin
            dmem[a0 + 10'd2] <= memDataIn[23:16];
            dmem[a0 + 10'd3] <= memDataIn[31:24];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycleCount);
      end
   endtask

   function automatic int accessBytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Reference load: gather bytes from the model memory, then extend.
   function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v;
      logic [31:0] a;
      v = 32'h0;
      for (int i = 0; i < accessBytes(f3); i++) begin
         a = addr + 32'(i);
         v = v | (32'(refMem[a[9:0]]) << (8 * i));
      end
      if (f3 == 3'b000 && v >= 32'd128)   v = v + 32'hFFFFFF00;
      if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
      return v;
   endfunction

   // Monitor: a result pulse must appear exactly on its due cycle, and never otherwise.
   always @(negedge clock) begin
      if (monitorOn && !reset) begin
         if (expQ.size() > 0 && expQ[0].due == cycleCount) begin
            monE = expQ.pop_front();
            checkOutput("load_valid", {31'b0, loadValid}, {31'b0, !monE.isFault});
            checkOutput("fault", {31'b0, fault}, {31'b0, monE.isFault});
            if (!monE.isFault) checkOutput("load_data", loadData, monE.data);
         end else begin
            checkOutput("no_pulse", {30'b0, loadValid, fault}, 32'h0);
         end
      end
   end

   // Present one access, hold it for the expected number of beats, check each beat.
   task automatic applyStimulus(input bit store, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int n, beats;
      bit illegal, mis;
      logic [31:0] a;
      n       = accessBytes(f3);
      illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
      mis     = !illegal && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
      beats   = mis ? n : 1;
      reqValid  = 1'b1;
      reqStore  = store;
      reqFunct3 = f3;
      reqAddr   = addr;
      reqWdata  = wdata;
      for (int k = 0; k < beats; k++) begin
         @(negedge clock);
         checkOutput("stall", {31'b0, stall}, {31'b0, (k != beats - 1)});
         checkOutput("mem_address", memAddr, mis ? addr + 32'(k) : addr);
         checkOutput("mem_rw", {31'b0, memRw}, {31'b0, (store && !illegal)});
         checkOutput("mem_size", {30'b0, memSize},
                     illegal ? 32'd2 : (mis ? 32'd0 : (n == 1 ? 32'd0 : (n == 2 ? 32'd1 : 32'd2))));
         @(posedge clock);
         #1;
      end
      if (illegal) begin
         expQ.push_back('{due: cycleCount, isFault: 1'b1, data: 32'h0});
      end else if (store) begin
         for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            refMem[a[9:0]] = wdata[8*i +: 8];
         end
      end else begin
         expQ.push_back('{due: cycleCount, isFault: 1'b0, data: refLoad(f3, addr)});
      end
   endtask

   task automatic idleCycle();
      reqValid = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0]  b;
      logic [2:0]  f3;
      logic [31:0] addr;

      reset     = 1'b1;
      reqValid  = 1'b0;
      reqStore  = 1'b0;
      reqFunct3 = 3'b000;
      reqAddr   = 32'h0;
      reqWdata  = 32'h0;
      for (int i = 0; i < 1024; i++) begin
         b = 8'($urandom_range(0, 255));
         dmem[i]   = b;
         refMem[i] = b;
      end
      dmem[10'h100] = 8'h01; refMem[10'h100] = 8'h01;
      dmem[10'h101] = 8'h7F; refMem[10'h101] = 8'h7F;
      dmem[10'h102] = 8'hFF; refMem[10'h102] = 8'hFF;
      dmem[10'h103] = 8'h80; refMem[10'h103] = 8'h80;
      dmem[10'h0FF] = 8'hAA; refMem[10'h0FF] = 8'hAA;

      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("reset_load_valid", {31'b0, loadValid}, 32'h0);
      checkOutput("reset_load_data", loadData, 32'h0);
      checkOutput("reset_fault", {31'b0, fault}, 32'h0);
      checkOutput("reset_stall", {31'b0, stall}, 32'h0);
      checkOutput("reset_mem_rw", {31'b0, memRw}, 32'h0);
      @(posedge clock);
      #1;
      reset     = 1'b0;
      monitorOn = 1'b1;

      $display("[TB] directed: aligned loads");
      applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
      idleCycle();
      applyStimulus(1'b0, 3'b000, 32'h102, 32'h0);
      applyStimulus(1'b0, 3'b100, 32'h102, 32'h0);
      applyStimulus(1'b0, 3'b001, 32'h102, 32'h0);
      idleCycle();

      $display("[TB] directed: misaligned store and loads");
      applyStimulus(1'b1, 3'b010, 32'h101, 32'h12345678);
      applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
      idleCycle();
      applyStimulus(1'b0, 3'b101, 32'h0FF, 32'h0);
      idleCycle();

      $display("[TB] directed: address wrap");
      applyStimulus(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
      applyStimulus(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
      idleCycle();

      $display("[TB] directed: reset during split store");
      reqValid  = 1'b1;
      reqStore  = 1'b1;
      reqFunct3 = 3'b010;
      reqAddr   = 32'h201;
      reqWdata  = 32'hA1B2C3D4;
      @(negedge clock);
      checkOutput("split_beat0_stall", {31'b0, stall}, 32'h1);
      checkOutput("split_beat0_rw", {31'b0, memRw}, 32'h1);
      @(posedge clock);
      #1;
      refMem[10'h201] = 8'hD4;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("reset_forces_rw_low", {31'b0, memRw}, 32'h0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      reqValid = 1'b0;
      @(negedge clock);
      checkOutput("after_abort_stall", {31'b0, stall}, 32'h0);
      checkOutput("after_abort_size", {30'b0, memSize}, 32'h2);
      @(posedge clock);
      #1;
      applyStimulus(1'b0, 3'b010, 32'h200, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h204, 32'h0);
      idleCycle();

      $display("[TB] directed: illegal funct3");
      applyStimulus(1'b0, 3'b011, 32'h100, 32'h0);
      idleCycle();
      applyStimulus(1'b1, 3'b100, 32'h104, 32'hDEADBEEF);
      applyStimulus(1'b0, 3'b111, 32'h101, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h104, 32'h0);
      idleCycle();

      $display("[TB] random accesses");
      for (int t = 0; t < 300; t++) begin
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
         else                           addr = 32'($urandom_range(0, 1023));
         applyStimulus(1'($urandom_range(0, 1)), f3, addr, $urandom);
         if ($urandom_range(0, 3) == 0) idleCycle();
      end

      repeat (3) idleCycle();
      checkOutput("pending_results", 32'(expQ.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
